// File: rtl/div_ctrl.sv
// Programmable clock divider: 50% duty O_CLK, low phase first, with a config
// handshake whose new half-period only takes effect on a period boundary.
module div_ctrl #(
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 2
) (
  input  logic             I_CLK,
  input  logic             Rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             O_CLK,
  output logic             O_TICK,
  output logic             active,
  output logic [CNT_W-1:0] half_cur
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] pend_half, pend_nxt;
  logic [CNT_W-1:0] half_nxt;
  logic             clk_nxt, tick_nxt, err_nxt;
  logic             cfg_take, cfg_zero;
  logic             phase_end, boundary, go_idle;

  assign cfg_ready = (state != PEND);
  assign active    = (state != IDLE);

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_CLK) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      O_CLK     <= 1'b0;
      O_TICK    <= 1'b0;
      cfg_err   <= 1'b0;
      half_cur  <= CNT_W'(DEF_HALF);
      pend_half <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      O_CLK     <= clk_nxt;
      O_TICK    <= tick_nxt;
      cfg_err   <= err_nxt;
      half_cur  <= half_nxt;
      pend_half <= pend_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    cfg_take  = cfg_valid & cfg_ready & (cfg_half != '0);
    cfg_zero  = cfg_valid & cfg_ready & (cfg_half == '0);
    phase_end = (cnt == half_cur - CNT_W'(1));
    boundary  = phase_end & O_CLK;
    // Stop at once while low; while high, only once the high phase has completed.
    go_idle   = ~run & (~O_CLK | phase_end);

    state_nxt = state;
    cnt_nxt   = cnt;
    clk_nxt   = O_CLK;
    tick_nxt  = 1'b0;
    err_nxt   = cfg_zero;
    half_nxt  = half_cur;
    pend_nxt  = pend_half;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
        if (cfg_take) half_nxt = cfg_half;
        if (run) state_nxt = RUN;
      end

      RUN, PEND: begin
        if (go_idle) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          clk_nxt   = 1'b0;
        end else if (phase_end) begin
          cnt_nxt  = '0;
          clk_nxt  = ~O_CLK;
          tick_nxt = ~O_CLK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end

        // A held-back half-period is committed whenever the output is about to
        // sit low at a clean period start: the boundary, or a stop.
        if (state == PEND) begin
          if (go_idle || boundary) begin
            half_nxt = pend_half;
            if (!go_idle) state_nxt = RUN;
          end
        end else if (cfg_take) begin
          if (go_idle) begin
            half_nxt = cfg_half;
          end else begin
            pend_nxt  = cfg_half;
            state_nxt = PEND;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        clk_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the half-period count.
REQ-002 The block SHALL have parameter DEF_HALF, default 2, giving the half-period loaded at reset (DEF_HALF >= 1).
REQ-003 The block SHALL have port I_CLK, input, 1 bit: clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port run, input, 1 bit: level request to generate the divided clock.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: new half-period offered.
REQ-007 The block SHALL have port cfg_half, input, CNT_W bits: offered half-period, counted in I_CLK cycles.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: block can accept a config.
REQ-009 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a zero half-period is rejected.
REQ-010 The block SHALL have port O_CLK, output, 1 bit: divided clock, 50% duty, low phase first.
REQ-011 The block SHALL have port O_TICK, output, 1 bit: one-cycle pulse marking each O_CLK rising edge.
REQ-012 The block SHALL have port active, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port half_cur, output, CNT_W bits: half-period currently in use.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and PEND (config accepted, waiting for a period boundary).
REQ-015 In RUN and PEND, cnt SHALL increment each cycle; when cnt == half_cur-1, O_CLK SHALL toggle and cnt SHALL clear, giving a period of 2*half_cur I_CLK cycles.
REQ-016 The period boundary SHALL be the cycle in which O_CLK toggles 1->0.
REQ-017 O_TICK SHALL be 1 exactly in the first cycle in which registered O_CLK is 1; otherwise it SHALL be 0.
REQ-018 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-019 A config transfer SHALL occur when cfg_valid & cfg_ready & (cfg_half != 0).
REQ-020 When cfg_valid & cfg_ready & cfg_half == 0, cfg_err SHALL pulse on the next cycle, no transfer SHALL occur, and state SHALL be unchanged.
REQ-021 A transfer in IDLE SHALL load half_cur on the next edge.
REQ-022 A transfer in RUN SHALL store the value in pend_half and move to PEND; half_cur SHALL be unchanged.
REQ-023 At the period boundary in PEND, half_cur SHALL load pend_half, cnt SHALL be 0, O_CLK SHALL be 0, and the FSM SHALL return to RUN, so no partial or short phase ever appears on O_CLK.
REQ-024 IDLE -> RUN SHALL occur on an edge with run=1; O_CLK SHALL stay 0 for half_cur cycles, then rise.
REQ-025 If run=0 in RUN or PEND with O_CLK=0, the block SHALL enter IDLE on the next edge with cnt=0.
REQ-026 If run=0 in RUN or PEND with O_CLK=1, the block SHALL continue to the period boundary and then enter IDLE; a pending config SHALL be applied at that boundary.
REQ-027 run=1 together with a config transfer in IDLE SHALL start with the new half_cur, and the first low phase SHALL last cfg_half cycles.
REQ-028 In IDLE, O_CLK SHALL be 0, O_TICK SHALL be 0 and cnt SHALL be 0.
REQ-029 The counter SHALL be CNT_W bits wide; half_cur = 2^CNT_W-1 SHALL be supported without overflow.

Reset
REQ-030 With Rst=1 at an edge, the block SHALL set state=IDLE, cnt=0, O_CLK=0, O_TICK=0, cfg_err=0, half_cur=DEF_HALF, pend_half=0 and cfg_ready=1.
REQ-031 Rst SHALL take priority over run and cfg_valid, and a pending config SHALL be discarded.
REQ-032 Reset asserted mid-phase SHALL force O_CLK low on the next edge, with no completion of the current phase.

Verification
REQ-033 Reset, then run=1 held with default half=2 -> O_CLK pattern 0,0,1,1 repeating; O_TICK high once per 4 cycles, aligned with the first high cycle.
REQ-034 In IDLE, cfg_half=5 with cfg_valid for one cycle, then run=1 -> half_cur=5; O_CLK low 5 cycles, high 5 cycles; period 10.
REQ-035 Running at half=3, at mid high-phase send cfg_half=1 -> cfg_ready drops; the high phase completes its full 3 cycles; thereafter O_CLK toggles every cycle; cfg_ready returns to 1 at the boundary.
REQ-036 cfg_half=0 with cfg_valid -> cfg_err pulses for 1 cycle; half_cur and state are unchanged.
REQ-037 Running at half=4, drop run at the 2nd high cycle -> 2 more high cycles, then O_CLK=0, active=0.
REQ-038 Running at half=4, assert Rst for 1 cycle during a high phase -> next cycle O_CLK=0, half_cur=2, state IDLE.
